imem_load_arbiter: RTL and testbench

- Owns the single port of the instruction memory (prgrom-style, synchronous read, 1-cycle latency).
- Shares that port between the CPU fetch path (PC[15:2]) and a UART program-download byte stream.
- Sequences the mode changes: run, load, and flush. While loading it holds the CPU in reset so the PC restarts at 0 on the new program.

---
 rtl/imem_load_arbiter_pkg.sv | 25 ++
 rtl/imem_load_arbiter_packer.sv | 63 ++++++
 rtl/imem_load_arbiter.sv | 178 +++++++++++++++++
 tb/tb_imem_load_arbiter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_load_arbiter_pkg.sv
// Shared definitions for the instruction-memory load arbiter.
//   arb_state_t          : arbiter modes (run, load, flush)
//   ISA_WIDTH            : default instruction word width
//   NOP                  : instruction presented to fetch while the CPU is held
//   DEFAULT_IDLE_TIMEOUT : default idle cycles that end a download
//   width_for            : bits needed to hold values 0..max_value
package imem_load_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2
    } arb_state_t;

    localparam int          ISA_WIDTH            = 32;
    localparam logic [31:0] NOP                  = 32'h0000_0000;
    localparam int          DEFAULT_IDLE_TIMEOUT = 50000;

    function automatic int width_for(input int max_value);
        int w;
        w = $clog2(max_value + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/imem_load_arbiter_packer.sv
// Assembles a little-endian instruction word from a UART byte stream.
// Ports:
//   clock, reset   : system clock, asynchronous active-high reset
//   clear          : synchronous clear of the byte counter
//   enable         : bytes are accepted only while high
//   byte_valid     : strobe, byte_data valid this cycle
//   byte_data      : received byte
//   word           : assembled word (valid while word_valid)
//   word_valid     : high for the one cycle after the last byte of a word
//   complete_next  : the byte taken this cycle completes a word
//   partial_next   : after this edge the counter holds an incomplete word
module byte_word_packer
    import imem_load_arbiter_pkg::*;
#(
    parameter int ISA_WIDTH = imem_load_arbiter_pkg::ISA_WIDTH
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 enable,
    input  logic                 byte_valid,
    input  logic [7:0]           byte_data,
    output logic [ISA_WIDTH-1:0] word,
    output logic                 word_valid,
    output logic                 complete_next,
    output logic                 partial_next
);

    localparam int BPW = ISA_WIDTH / 8;
    localparam int CW  = width_for(BPW);

    logic [CW-1:0] count;
    logic [CW-1:0] base;
    logic [CW-1:0] count_next;
    logic          take;

    // count == BPW marks the write cycle; the counter restarts from zero
    // on the following edge, so a byte arriving then starts the next word.
    always_comb begin
        base       = (count == CW'(BPW)) ? '0 : count;
        take       = enable && byte_valid;
        count_next = take ? base + 1'b1 : base;
    end

    assign word_valid    = (count == CW'(BPW));
    assign complete_next = take && (count_next == CW'(BPW));
    assign partial_next  = (count_next != '0) && (count_next != CW'(BPW));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
            word  <= '0;
        end else if (clear) begin
            count <= '0;
        end else begin
            count <= count_next;
            if (take) begin
                word[int'(base) * 8 +: 8] <= byte_data;
            end
        end
    end

endmodule

// File: rtl/imem_load_arbiter.sv
// Owns the single port of the instruction memory and shares it between
// CPU fetch and a UART program download, holding the CPU in reset while
// a new program is loaded and flushing the read path before release.
// Ports:
//   clock, reset          : system clock, asynchronous active-high reset
//   fetch_addr/fetch_instr: CPU fetch word address and returned instruction
//   upg_start/upg_end     : download start/end pulses
//   byte_valid/byte_data  : UART byte stream
//   mem_addr/mem_we/mem_wdata/mem_rdata : memory port (1-cycle read latency)
//   cpu_hold              : holds the CPU in reset
//   load_done/load_err    : sticky load status (clean end / partial word)
//   word_count            : words written by the last load
module imem_load_arbiter
#(
    parameter int ADDR_WIDTH   = 14,
    parameter int ISA_WIDTH    = imem_load_arbiter_pkg::ISA_WIDTH,
    parameter int IDLE_TIMEOUT = imem_load_arbiter_pkg::DEFAULT_IDLE_TIMEOUT
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    output logic [ISA_WIDTH-1:0]  fetch_instr,
    input  logic                  upg_start,
    input  logic                  upg_end,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [ISA_WIDTH-1:0]  mem_wdata,
    input  logic [ISA_WIDTH-1:0]  mem_rdata,
    output logic                  cpu_hold,
    output logic                  load_done,
    output logic                  load_err,
    output logic [ADDR_WIDTH:0]   word_count
);

    import imem_load_arbiter_pkg::*;

    localparam int            IW       = width_for(IDLE_TIMEOUT);
    localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_TIMEOUT - 1);

    arb_state_t            state;
    arb_state_t            state_next;
    logic                  flush_cnt;
    logic [ADDR_WIDTH-1:0] addr_cnt;
    logic [IW-1:0]         idle_cnt;
    logic                  exit_pending;

    logic                  in_load;
    logic                  last_write;
    logic                  byte_en;
    logic                  timeout;
    logic                  exit_req;
    logic                  start_load;
    logic                  go_flush;
    logic                  set_pending;

    logic [ISA_WIDTH-1:0]  word;
    logic                  word_valid;
    logic                  complete_next;
    logic                  partial_next;

    assign in_load    = (state == ST_LOAD);
    assign last_write = word_valid && (addr_cnt == '1);
    // Bytes stop being accepted once an exit is decided (pending write
    // cycle or final write into the last address).
    assign byte_en    = in_load && !exit_pending && !last_write;
    assign timeout    = (idle_cnt == IDLE_MAX) && (word_count != '0);
    assign exit_req   = upg_end || timeout || exit_pending;
    assign mem_wdata  = word;

    byte_word_packer #(
        .ISA_WIDTH (ISA_WIDTH)
    ) u_packer (
        .clock         (clock),
        .reset         (reset),
        .clear         (!in_load),
        .enable        (byte_en),
        .byte_valid    (byte_valid),
        .byte_data     (byte_data),
        .word          (word),
        .word_valid    (word_valid),
        .complete_next (complete_next),
        .partial_next  (partial_next)
    );

    always_comb begin
        state_next  = state;
        mem_addr    = fetch_addr;
        fetch_instr = ISA_WIDTH'(NOP);
        mem_we      = 1'b0;
        cpu_hold    = 1'b0;
        start_load  = 1'b0;
        go_flush    = 1'b0;
        set_pending = 1'b0;
        case (state)
            ST_RUN: begin
                fetch_instr = mem_rdata;
                if (upg_start) begin
                    state_next = ST_LOAD;
                    start_load = 1'b1;
                end
            end
            ST_LOAD: begin
                cpu_hold = 1'b1;
                mem_addr = addr_cnt;
                mem_we   = word_valid;
                if (last_write) begin
                    go_flush = 1'b1;
                end else if (exit_req) begin
                    // A byte completing a word alongside the exit request
                    // gets its write cycle before leaving.
                    if (complete_next) begin
                        set_pending = 1'b1;
                    end else begin
                        go_flush = 1'b1;
                    end
                end
                if (go_flush) begin
                    state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                cpu_hold = 1'b1;
                mem_addr = '0;
                if (flush_cnt) begin
                    state_next = ST_RUN;
                end
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= ST_RUN;
            flush_cnt    <= 1'b0;
            addr_cnt     <= '0;
            word_count   <= '0;
            idle_cnt     <= '0;
            exit_pending <= 1'b0;
            load_done    <= 1'b0;
            load_err     <= 1'b0;
        end else begin
            state     <= state_next;
            flush_cnt <= (state == ST_FLUSH) && !flush_cnt;
            if (start_load) begin
                addr_cnt     <= '0;
                word_count   <= '0;
                idle_cnt     <= '0;
                exit_pending <= 1'b0;
                load_done    <= 1'b0;
                load_err     <= 1'b0;
            end else if (in_load) begin
                if (word_valid) begin
                    addr_cnt   <= addr_cnt + 1'b1;
                    word_count <= word_count + 1'b1;
                end
                if (byte_valid) begin
                    idle_cnt <= '0;
                end else if (idle_cnt != IDLE_MAX) begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
                if (set_pending) begin
                    exit_pending <= 1'b1;
                end
                if (go_flush) begin
                    exit_pending <= 1'b0;
                    load_err     <= partial_next;
                    load_done    <= !partial_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_imem_load_arbiter.sv
module tb_imem_load_arbiter;

    localparam int AW   = 3;
    localparam int IW   = 32;
    localparam int TOUT = 16;

    logic          clock = 1'b0;
    logic          reset;
    logic [AW-1:0] fetch_addr;
    logic [IW-1:0] fetch_instr;
    logic          upg_start;
    logic          upg_end;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [IW-1:0] mem_wdata;
    logic [IW-1:0] mem_rdata;
    logic          cpu_hold;
    logic          load_done;
    logic          load_err;
    logic [AW:0]   word_count;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    logic [31:0] mon_a;
    logic [31:0] mon_d;

    imem_load_arbiter #(
        .ADDR_WIDTH   (AW),
        .ISA_WIDTH    (IW),
        .IDLE_TIMEOUT (TOUT)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .fetch_addr  (fetch_addr),
        .fetch_instr (fetch_instr),
        .upg_start   (upg_start),
        .upg_end     (upg_end),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .cpu_hold    (cpu_hold),
        .load_done   (load_done),
        .load_err    (load_err),
        .word_count  (word_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Write monitor: every memory write must match the next expected one.
    always @(negedge clock) begin
        if (mem_we !== 1'b0) begin
            if (exp_addr.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr %h data %h want no write", mem_addr, mem_wdata);
            end else begin
                mon_a = exp_addr.pop_front();
                mon_d = exp_data.pop_front();
                check("write_addr", 32'(mem_addr), mon_a);
                check("write_data", mem_wdata, mon_d);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_write(input logic [31:0] a, input logic [31:0] d);
        exp_addr.push_back(a);
        exp_data.push_back(d);
    endtask

    task automatic pulse_start();
        upg_start = 1'b1;
        tick();
        upg_start = 1'b0;
    endtask

    task automatic pulse_end();
        upg_end = 1'b1;
        tick();
        upg_end = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_data  = b;
        tick();
        byte_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[i*8 +: 8]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [31:0] w;
        reset      = 1'b1;
        fetch_addr = '0;
        upg_start  = 1'b0;
        upg_end    = 1'b0;
        byte_valid = 1'b0;
        byte_data  = '0;
        mem_rdata  = '0;
        tick();
        tick();
        check("rst_cpu_hold", 32'(cpu_hold), 0);
        check("rst_mem_we", 32'(mem_we), 0);
        check("rst_load_done", 32'(load_done), 0);
        check("rst_load_err", 32'(load_err), 0);
        check("rst_word_count", 32'(word_count), 0);
        reset = 1'b0;
        tick();

        // RUN pass-through
        fetch_addr = 3'd5;
        mem_rdata  = 32'h2008_0001;
        #1;
        check("run_mem_addr", 32'(mem_addr), 5);
        check("run_fetch_instr", fetch_instr, 32'h2008_0001);
        check("run_cpu_hold", 32'(cpu_hold), 0);
        check("run_mem_we", 32'(mem_we), 0);

        // Two-word load ended by upg_end
        pulse_start();
        check("load_cpu_hold", 32'(cpu_hold), 1);
        check("load_fetch_nop", fetch_instr, 32'h0);
        check("load_mem_addr", 32'(mem_addr), 0);
        expect_write(0, 32'h2008_0001);
        send_word(32'h2008_0001);
        expect_write(1, 32'h2009_0002);
        send_word(32'h2009_0002);
        check("load_word_count_mid", 32'(word_count), 2);
        pulse_end();
        check("flush1_cpu_hold", 32'(cpu_hold), 1);
        check("flush1_mem_addr", 32'(mem_addr), 0);
        check("flush1_fetch_nop", fetch_instr, 32'h0);
        check("l1_load_done", 32'(load_done), 1);
        check("l1_load_err", 32'(load_err), 0);
        check("l1_word_count", 32'(word_count), 2);
        tick();
        check("flush2_cpu_hold", 32'(cpu_hold), 1);
        tick();
        check("after_flush_cpu_hold", 32'(cpu_hold), 0);
        check("after_flush_mem_addr", 32'(mem_addr), 5);

        // Six bytes: one word plus a discarded partial
        pulse_start();
        check("l2_cleared_done", 32'(load_done), 0);
        check("l2_cleared_count", 32'(word_count), 0);
        expect_write(0, 32'h4433_2211);
        send_word(32'h4433_2211);
        send_byte(8'h55);
        send_byte(8'h66);
        pulse_end();
        check("l2_load_err", 32'(load_err), 1);
        check("l2_load_done", 32'(load_done), 0);
        check("l2_word_count", 32'(word_count), 1);
        tick();
        tick();
        check("l2_cpu_hold", 32'(cpu_hold), 0);

        // Idle timeout: no exit while zero words written, then timeout
        pulse_start();
        for (int i = 0; i < TOUT + 4; i++) tick();
        check("idle_nowords_hold", 32'(cpu_hold), 1);
        check("idle_nowords_done", 32'(load_done), 0);
        expect_write(0, 32'hDEAD_BEEF);
        send_word(32'hDEAD_BEEF);
        n = 0;
        while (load_done !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check("timeout_cycles", n, TOUT - 2);
        check("timeout_word_count", 32'(word_count), 1);
        check("timeout_load_err", 32'(load_err), 0);
        check("timeout_cpu_hold", 32'(cpu_hold), 1);
        tick();
        tick();
        check("timeout_release", 32'(cpu_hold), 0);

        // Memory full: 36 bytes, only 8 words written
        pulse_start();
        for (int i = 0; i < 8; i++) begin
            w = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
            expect_write(i, w);
        end
        for (int j = 0; j < 36; j++) begin
            send_byte(8'(j));
        end
        check("full_word_count", 32'(word_count), 8);
        check("full_load_done", 32'(load_done), 1);
        check("full_load_err", 32'(load_err), 0);
        check("full_cpu_hold", 32'(cpu_hold), 0);

        // Fourth byte coincides with upg_end
        pulse_start();
        send_byte(8'h78);
        send_byte(8'h56);
        send_byte(8'h34);
        expect_write(0, 32'h1234_5678);
        byte_valid = 1'b1;
        byte_data  = 8'h12;
        upg_end    = 1'b1;
        tick();
        byte_valid = 1'b0;
        upg_end    = 1'b0;
        check("coinc_write_cycle_hold", 32'(cpu_hold), 1);
        check("coinc_write_cycle_done", 32'(load_done), 0);
        tick();
        check("coinc_load_done", 32'(load_done), 1);
        check("coinc_word_count", 32'(word_count), 1);
        tick();
        tick();
        check("coinc_release", 32'(cpu_hold), 0);

        // Reset in the middle of a load
        pulse_start();
        send_byte(8'hAA);
        send_byte(8'hBB);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_cpu_hold", 32'(cpu_hold), 0);
        check("midrst_word_count", 32'(word_count), 0);
        check("midrst_mem_addr", 32'(mem_addr), 5);
        tick();
        reset = 1'b0;
        tick();
        pulse_start();
        expect_write(0, 32'hCAFE_0123);
        send_word(32'hCAFE_0123);
        pulse_end();
        check("postrst_load_done", 32'(load_done), 1);
        check("postrst_word_count", 32'(word_count), 1);
        tick();
        tick();
        check("postrst_release", 32'(cpu_hold), 0);
        tick();

        check("writes_outstanding", exp_addr.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
